prim_skid_buf: RTL and testbench

Two-entry valid/ready register slice (skid buffer) that cuts every combinational path between an upstream producer and a downstream consumer. Data travels forward through registered storage. Backpressure travels back as a registered `ready_o`, so full throughput is kept without a ready path through the block. It sits between `prim` storage flops and bus/stream pipelines wherever timing closure needs a full register break on both the forward and backward paths.

---
 rtl/prim_skid_buf.sv | 117 +++++++++++
 tb/tb_prim_skid_buf.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/prim_skid_buf.sv
// rtl/prim_skid_buf.sv - two-entry valid/ready skid buffer with fully registered outputs
// Optional synchronous flush port clr_i enabled by defining PRIM_SKID_BUF_CLR_EN.
module prim_skid_buf #(
  parameter int               Width      = 32,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
`ifdef PRIM_SKID_BUF_CLR_EN
  ,
  input  logic             clr_i
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [Width-1:0] r_main;
  logic [Width-1:0] r_skid;
  logic [Width-1:0] w_main_d;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_push;
  logic             w_pop;
  logic             w_clr;

`ifdef PRIM_SKID_BUF_CLR_EN
  assign w_clr = clr_i;
`else
  assign w_clr = 1'b0;
`endif

  assign w_push = valid_i & ready_o;
  assign w_pop  = valid_o & ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_main_en = 1'b0;
    w_main_d  = data_i;
    w_skid_en = 1'b0;
    case (r_state)
      StEmpty: begin
        if (w_push) begin
          w_state_d = StOne;
          w_main_en = 1'b1;
        end
      end
      StOne: begin
        if (w_push && !w_pop) begin
          w_state_d = StTwo;
          w_skid_en = 1'b1;
        end else if (w_push && w_pop) begin
          w_main_en = 1'b1;
        end else if (w_pop) begin
          w_state_d = StEmpty;
          w_main_en = 1'b1;
          w_main_d  = ResetValue;
        end
      end
      StTwo: begin
        // ready_o is low here, so only a pop can move the state
        if (w_pop) begin
          w_state_d = StOne;
          w_main_en = 1'b1;
          w_main_d  = r_skid;
        end
      end
      default: begin
        w_state_d = StEmpty;
        w_main_en = 1'b1;
        w_main_d  = ResetValue;
      end
    endcase
    if (w_clr) begin
      w_state_d = StEmpty;
      w_main_en = 1'b1;
      w_main_d  = ResetValue;
      w_skid_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main <= ResetValue;
      r_skid <= ResetValue;
    end else begin
      if (w_main_en) r_main <= w_main_d;
      if (w_skid_en) r_skid <= data_i;
    end
  end

  always_comb begin
    valid_o = (r_state != StEmpty);
    ready_o = (r_state != StTwo);
    data_o  = r_main;
  end

endmodule

// File: tb/tb_prim_skid_buf.sv
// tb/tb_prim_skid_buf.sv - randomized self-checking bench for prim_skid_buf against a queue model
module tb_prim_skid_buf;
  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;
`ifdef PRIM_SKID_BUF_CLR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  data_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  data_o;
  logic          clr;

  int n_cmp;
  int n_bad;

  logic [31:0] mq[$];
  logic [31:0] sb[$];

  prim_skid_buf #(.Width(W), .ResetValue(RV)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
`ifdef PRIM_SKID_BUF_CLR_EN
    ,
    .clr_i   (clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check_val("valid_o", {31'b0, valid_o}, {31'b0, mq.size() > 0});
    check_val("ready_o", {31'b0, ready_o}, {31'b0, mq.size() < 2});
    check_val("data_o", data_o, (mq.size() > 0) ? mq[0] : RV);
  endtask

  // Called at a falling edge; drives inputs, runs one rising edge, checks at the next falling edge.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c);
    logic m_push;
    logic m_pop;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    clr     = c;
    #1;
    m_push = v && (mq.size() < 2);
    m_pop  = (mq.size() > 0) && r;
    if (c && ClrEn) begin
      sb.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (sb.size() == 0) check_val("pop_without_push", {31'b0, valid_o}, 32'd0);
        else check_val("order", data_o, sb.pop_front());
      end
      if (valid_i && ready_o) sb.push_back(data_i);
    end
    @(posedge clk);
    if (c && ClrEn) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(d);
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    clr     = 1'b0;
    #3;
    check_val("rst_valid", {31'b0, valid_o}, 32'd0);
    check_val("rst_ready", {31'b0, ready_o}, 32'd1);
    check_val("rst_data", data_o, RV);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 16; i++) step(1'b1, i, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h5, 1'b1, 1'b0);
    step(1'b1, 32'h6, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b1, 32'h88, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    sb.delete();
    check_val("async_rst_valid", {31'b0, valid_o}, 32'd0);
    check_val("async_rst_ready", {31'b0, ready_o}, 32'd1);
    check_val("async_rst_data", data_o, RV);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    if (ClrEn) begin
      step(1'b1, 32'h1, 1'b0, 1'b0);
      step(1'b1, 32'h2, 1'b0, 1'b0);
      step(1'b1, 32'h3, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    end

    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
